// File: rtl/xoodoo_sponge_ctrl.sv
// Sponge/duplex front-end for the XOODOO permutation: absorbs padded message blocks, then squeezes digest blocks.
// Optional permutation watchdog enabled by defining XOODOO_PERM_TIMEOUT_EN.
module xoodoo_sponge_ctrl #(
  parameter logic [7:0] DOMAIN         = 8'h03,
  parameter int         DIGEST_BLOCKS  = 2,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [0:127]   in_data,
  input  logic [4:0]     in_bytes,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [0:127]   out_data,
  output logic           out_last,
  output logic           perm_enable,
  output logic [0:383]   perm_state,
  input  logic [0:383]   perm_result,
  input  logic           perm_done,
  output logic           busy,
  output logic           err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ABSORB   = 3'd1;
  localparam logic [2:0] S_KICK     = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_SQZ_KICK = 3'd4;
  localparam logic [2:0] S_SQZ_WAIT = 3'd5;
  localparam logic [2:0] S_OUT      = 3'd6;

  if (DIGEST_BLOCKS < 1 || DIGEST_BLOCKS > 4 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_params
    $error("xoodoo_sponge_ctrl: DIGEST_BLOCKS must be 1..4 and TIMEOUT_CYCLES 2..255");
  end

  logic [2:0]   fsm;
  logic [0:383] state;
  logic         first;
  logic         last_blk;
  logic         perm_pending;
  logic [2:0]   sqz_cnt;
  logic         halt;
  logic         tmo_hit;
  logic         final_blk;

  logic [4:0]   n_bytes;
  logic [0:127] blk_masked;
  logic [0:383] absorbed;

  // Padded absorb of the presented block; only committed on an ABSORB handshake.
  always_comb begin
    n_bytes    = (in_bytes > 5'd16) ? 5'd16 : in_bytes;
    blk_masked = in_data;
    for (int k = 0; k < 16; k++) begin
      if (in_last && (5'(k) >= n_bytes)) begin
        blk_masked[8*k +: 8] = 8'h00;
      end
    end
    absorbed          = state;
    absorbed[0:127]   = state[0:127] ^ blk_masked;
    for (int k = 0; k <= 16; k++) begin
      if (in_last && (5'(k) == n_bytes)) begin
        absorbed[8*k +: 8] = absorbed[8*k +: 8] ^ 8'h01;
      end
    end
    if (first) begin
      absorbed[376:383] = absorbed[376:383] ^ DOMAIN;
    end
  end

  assign final_blk = (sqz_cnt == 3'(DIGEST_BLOCKS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm          <= S_IDLE;
      state        <= '0;
      first        <= 1'b1;
      last_blk     <= 1'b0;
      perm_pending <= 1'b0;
      sqz_cnt      <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (!halt) begin
            fsm      <= S_ABSORB;
            state    <= '0;
            first    <= 1'b1;
            last_blk <= 1'b0;
            sqz_cnt  <= '0;
          end
        end
        S_ABSORB: begin
          if (in_valid) begin
            state    <= absorbed;
            first    <= 1'b0;
            last_blk <= in_last;
            fsm      <= S_KICK;
          end
        end
        S_KICK: fsm <= S_WAIT;
        S_WAIT: begin
          if (perm_done) begin
            state <= perm_result;
            fsm   <= last_blk ? S_SQZ_WAIT : S_ABSORB;
          end
        end
        S_SQZ_KICK: begin
          perm_pending <= 1'b1;
          fsm          <= S_SQZ_WAIT;
        end
        // Entered with no permutation outstanding after the final absorb, so it falls straight through.
        S_SQZ_WAIT: begin
          if (!perm_pending) begin
            fsm <= S_OUT;
          end else if (perm_done) begin
            state        <= perm_result;
            perm_pending <= 1'b0;
            fsm          <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready && !halt) begin
            sqz_cnt <= sqz_cnt + 3'd1;
            if (final_blk) begin
              fsm <= S_IDLE;
            end else begin
              state[0:7] <= state[0:7] ^ 8'h01;
              fsm        <= S_SQZ_KICK;
            end
          end
        end
        default: fsm <= S_IDLE;
      endcase
      if (tmo_hit) begin
        state        <= '0;
        perm_pending <= 1'b0;
        fsm          <= S_IDLE;
      end
    end
  end

`ifdef XOODOO_PERM_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;
  logic       waiting;

  assign waiting = (fsm == S_WAIT) || ((fsm == S_SQZ_WAIT) && perm_pending);
  assign tmo_hit = waiting && !perm_done && ((tmo_cnt + 8'd1) == 8'(TIMEOUT_CYCLES));

  // The enable cycle itself counts, so err rises exactly TIMEOUT_CYCLES cycles after perm_enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (perm_enable) begin
        tmo_cnt <= 8'd1;
      end else if (waiting) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign halt = err_q;
  assign err  = err_q;
`else
  assign tmo_hit = 1'b0;
  assign halt    = 1'b0;
  assign err     = 1'b0;
`endif

  assign in_ready    = (fsm == S_ABSORB);
  assign perm_enable = (fsm == S_KICK) || (fsm == S_SQZ_KICK);
  assign perm_state  = state;
  assign out_valid   = (fsm == S_OUT) && !halt;
  assign out_data    = state[0:127];
  assign out_last    = out_valid && final_blk;
  assign busy        = (fsm != S_IDLE);

endmodule
